// File: rtl/n1_marb.sv
// ---------------------------------------------------------------------------
// n1_marb : N-channel bus arbiter/merger.
//   Several initiator channels share one pipelined bus. One channel at a
//   time owns the bus for a whole cycle (cyc held). Arbitration happens only
//   from IDLE, so there is always one idle bus cycle between owners. The
//   arbiter counts accepted-but-unanswered requests and throttles stb once
//   MAX_OUTST are in flight.
//
// Ports
//   clk_i, async_rst_i      : clock, asynchronous active-low reset
//   sbus_*_o                : merged initiator side (cyc/stb/we/adr/dat, one-hot owner tag)
//   sbus_*_i                : merged target side (ack/err/rty/stall, read data)
//   ch_*_i                  : per-channel requests, channel k in slice k
//   ch_*_o                  : per-channel responses/stall, shared read data
//   prb_state_o/gnt_o/outst_o : state (0 IDLE, 1 BUSY), grant, outstanding count
// ---------------------------------------------------------------------------
module n1_marb #(
  parameter int N_CH      = 2,
  parameter int ADR_WIDTH = 12,
  parameter int DAT_WIDTH = 16,
  parameter int RR        = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk_i,
  input  logic                      async_rst_i,
  output logic                      sbus_cyc_o,
  output logic                      sbus_stb_o,
  output logic                      sbus_we_o,
  output logic [ADR_WIDTH-1:0]      sbus_adr_o,
  output logic [DAT_WIDTH-1:0]      sbus_dat_o,
  output logic [N_CH-1:0]           sbus_tga_o,
  input  logic                      sbus_ack_i,
  input  logic                      sbus_err_i,
  input  logic                      sbus_rty_i,
  input  logic                      sbus_stall_i,
  input  logic [DAT_WIDTH-1:0]      sbus_dat_i,
  input  logic [N_CH-1:0]           ch_cyc_i,
  input  logic [N_CH-1:0]           ch_stb_i,
  input  logic [N_CH-1:0]           ch_we_i,
  input  logic [N_CH*ADR_WIDTH-1:0] ch_adr_i,
  input  logic [N_CH*DAT_WIDTH-1:0] ch_dat_i,
  output logic [N_CH-1:0]           ch_ack_o,
  output logic [N_CH-1:0]           ch_err_o,
  output logic [N_CH-1:0]           ch_rty_o,
  output logic [N_CH-1:0]           ch_stall_o,
  output logic [DAT_WIDTH-1:0]      ch_dat_o,
  output logic                      prb_state_o,
  output logic [N_CH-1:0]           prb_gnt_o,
  output logic [3:0]                prb_outst_o
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [3:0] MAXO = 4'(MAX_OUTST);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q;
  logic [N_CH-1:0] gnt_q;
  logic [3:0]      outst_q, outst_d;
  logic [PW-1:0]   ptr_q;     // last granted channel (round-robin origin)

  logic                 busy, resp_v, full, accept;
  logic                 g_cyc, g_stb, g_we;
  logic [ADR_WIDTH-1:0] g_adr;
  logic [DAT_WIDTH-1:0] g_dat;
  logic [N_CH-1:0]      win_oh;
  logic [PW-1:0]        win_idx;
  logic                 win_vld;

  assign busy = (state_q == BUSY);

  // Granted-channel mux; gnt_q is one-hot or zero.
  always_comb begin
    g_adr = '0;
    g_dat = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (gnt_q[j]) begin
        g_adr = ch_adr_i[j*ADR_WIDTH +: ADR_WIDTH];
        g_dat = ch_dat_i[j*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end
  assign g_cyc = |(ch_cyc_i & gnt_q);
  assign g_stb = |(ch_stb_i & gnt_q);
  assign g_we  = |(ch_we_i  & gnt_q);

  // A response with nothing outstanding is stray and dropped entirely.
  assign resp_v = busy & (outst_q != 4'd0) & (sbus_ack_i | sbus_err_i | sbus_rty_i);
  // At the limit, a same-cycle response frees a slot for a new request.
  assign full   = (outst_q == MAXO) & ~resp_v;

  assign sbus_cyc_o = busy & g_cyc;
  assign sbus_stb_o = busy & g_stb & ~full;
  assign sbus_we_o  = busy & g_we;
  assign sbus_adr_o = busy ? g_adr : '0;
  assign sbus_dat_o = busy ? g_dat : '0;
  assign sbus_tga_o = busy ? gnt_q : '0;
  assign accept     = sbus_stb_o & ~sbus_stall_i;

  assign ch_stall_o = busy ? (~gnt_q | {N_CH{sbus_stall_i | full}}) : '1;
  assign ch_ack_o   = {N_CH{resp_v & sbus_ack_i}} & gnt_q;
  assign ch_err_o   = {N_CH{resp_v & sbus_err_i}} & gnt_q;
  assign ch_rty_o   = {N_CH{resp_v & sbus_rty_i}} & gnt_q;
  assign ch_dat_o   = sbus_dat_i;

  assign prb_state_o = busy;
  assign prb_gnt_o   = gnt_q;
  assign prb_outst_o = outst_q;

  // Winner search. Round-robin: first requester above the pointer, else the
  // lowest requester (wrap). Fixed priority: first pass alone picks lowest.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (!win_vld && ch_cyc_i[j] && (RR == 0 || j > int'(ptr_q))) begin
        win_vld   = 1'b1;
        win_idx   = PW'(j);
        win_oh[j] = 1'b1;
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (!win_vld && ch_cyc_i[j]) begin
        win_vld   = 1'b1;
        win_idx   = PW'(j);
        win_oh[j] = 1'b1;
      end
    end
  end

  // Accept and response in the same cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    if (accept && !resp_v)      outst_d = outst_q + 4'd1;
    else if (resp_v && !accept) outst_d = outst_q - 4'd1;
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      outst_q <= '0;
      ptr_q   <= PW'(N_CH - 1);
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          state_q <= BUSY;
          gnt_q   <= win_oh;
          ptr_q   <= win_idx;
        end
        BUSY: if (!g_cyc) begin
          // Owner ended its cycle: abort anything still in flight.
          state_q <= IDLE;
          gnt_q   <= '0;
          outst_q <= '0;
        end else begin
          outst_q <= outst_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n1_marb.sv
// Bench for n1_marb: two instances (round-robin MAX_OUTST=3, fixed priority
// MAX_OUTST=2) share one stimulus; a channel-level reference model checks
// every output of both every cycle, alongside a vector table and directed
// sequences.
module tb_n1_marb;

  typedef struct packed {
    logic        cyc, stb, we;
    logic [11:0] adr;
    logic [15:0] dat;
    logic [3:0]  tga, ack, err, rty, stall;
    logic [15:0] cdat;
    logic        st;
    logic [3:0]  gnt, outst;
  } obs_t;

  typedef struct {
    logic [3:0] cyc, stb;
    logic       ack, err, stall;
    logic       st;
    logic [3:0] gnt, outst;
    logic       sstb;
    logic [3:0] acko, erro, stl;
  } vec_t;

  logic        clk, rst_n;
  logic [3:0]  cyc, stb, we;
  logic [47:0] adr;
  logic [63:0] dat;
  logic        ack, err, rty, stall;
  logic [15:0] sdat;

  logic r_cyc, r_stb, r_we, r_st, f_cyc, f_stb, f_we, f_st;
  logic [11:0] r_adr, f_adr;
  logic [15:0] r_dat, f_dat, r_cdat, f_cdat;
  logic [3:0]  r_tga, r_ack, r_err, r_rty, r_stl, r_gnt, r_out;
  logic [3:0]  f_tga, f_ack, f_err, f_rty, f_stl, f_gnt, f_out;
  obs_t got_r, got_f;

  int tests = 0, fails = 0;

  n1_marb #(.N_CH(4), .ADR_WIDTH(12), .DAT_WIDTH(16), .RR(1), .MAX_OUTST(3)) u_rr (
    .clk_i(clk), .async_rst_i(rst_n),
    .sbus_cyc_o(r_cyc), .sbus_stb_o(r_stb), .sbus_we_o(r_we), .sbus_adr_o(r_adr),
    .sbus_dat_o(r_dat), .sbus_tga_o(r_tga),
    .sbus_ack_i(ack), .sbus_err_i(err), .sbus_rty_i(rty), .sbus_stall_i(stall), .sbus_dat_i(sdat),
    .ch_cyc_i(cyc), .ch_stb_i(stb), .ch_we_i(we), .ch_adr_i(adr), .ch_dat_i(dat),
    .ch_ack_o(r_ack), .ch_err_o(r_err), .ch_rty_o(r_rty), .ch_stall_o(r_stl), .ch_dat_o(r_cdat),
    .prb_state_o(r_st), .prb_gnt_o(r_gnt), .prb_outst_o(r_out));

  n1_marb #(.N_CH(4), .ADR_WIDTH(12), .DAT_WIDTH(16), .RR(0), .MAX_OUTST(2)) u_fp (
    .clk_i(clk), .async_rst_i(rst_n),
    .sbus_cyc_o(f_cyc), .sbus_stb_o(f_stb), .sbus_we_o(f_we), .sbus_adr_o(f_adr),
    .sbus_dat_o(f_dat), .sbus_tga_o(f_tga),
    .sbus_ack_i(ack), .sbus_err_i(err), .sbus_rty_i(rty), .sbus_stall_i(stall), .sbus_dat_i(sdat),
    .ch_cyc_i(cyc), .ch_stb_i(stb), .ch_we_i(we), .ch_adr_i(adr), .ch_dat_i(dat),
    .ch_ack_o(f_ack), .ch_err_o(f_err), .ch_rty_o(f_rty), .ch_stall_o(f_stl), .ch_dat_o(f_cdat),
    .prb_state_o(f_st), .prb_gnt_o(f_gnt), .prb_outst_o(f_out));

  assign got_r = {r_cyc, r_stb, r_we, r_adr, r_dat, r_tga, r_ack, r_err, r_rty, r_stl, r_cdat, r_st, r_gnt, r_out};
  assign got_f = {f_cyc, f_stb, f_we, f_adr, f_dat, f_tga, f_ack, f_err, f_rty, f_stl, f_cdat, f_st, f_gnt, f_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, whether a channel owns the bus, which
  // one, how many requests are in flight, and the last owner.
  int m_busy[2] = '{0, 0};
  int m_own[2]  = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_last[2] = '{3, 3};

  function automatic int maxo(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  function automatic bit m_resp(input int d);
    return m_busy[d] != 0 && m_cnt[d] > 0 && (ack || err || rty);
  endfunction

  function automatic obs_t mexp(input int d);
    obs_t o;
    bit full;
    int w;
    o = '0;
    w = m_own[d];
    full = m_busy[d] != 0 && m_cnt[d] == maxo(d) && !m_resp(d);
    o.stall = 4'hF;
    o.cdat  = sdat;
    o.st    = (m_busy[d] != 0);
    o.outst = 4'(m_cnt[d]);
    if (m_busy[d] != 0) begin
      o.cyc = cyc[w];
      o.stb = stb[w] && !full;
      o.we  = we[w];
      o.adr = adr[w*12 +: 12];
      o.dat = dat[w*16 +: 16];
      o.tga = 4'(1 << w);
      o.gnt = o.tga;
      o.stall[w] = stall | full;
      if (m_cnt[d] > 0) begin
        o.ack[w] = ack;
        o.err[w] = err;
        o.rty[w] = rty;
      end
    end
    return o;
  endfunction

  function automatic void mstep(input int d);
    obs_t o;
    bit rv, acc;
    int w, pick, k;
    o = mexp(d);
    w = m_own[d];
    rv = m_resp(d);
    acc = o.stb && !stall;
    pick = -1;
    if (m_busy[d] == 0) begin
      if (cyc != 4'd0) begin
        for (int i = 1; i <= 4; i++) begin
          k = (d == 0) ? (m_last[d] + i) % 4 : i - 1;
          if (pick < 0 && cyc[k]) pick = k;
        end
        m_busy[d] = 1;
        m_own[d]  = pick;
        m_last[d] = pick;
      end
    end else if (!cyc[w]) begin
      m_busy[d] = 0;
      m_cnt[d]  = 0;
    end else if (acc && !rv) begin
      m_cnt[d]++;
    end else if (rv && !acc) begin
      m_cnt[d]--;
    end
  endfunction

  always @(negedge clk) begin
    obs_t e, g;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_cnt[d] = 0; m_last[d] = 3;
      end
    end
    for (int d = 0; d < 2; d++) begin
      e = mexp(d);
      g = (d == 0) ? got_r : got_f;
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", d, $time, g, e);
      end
      if (rst_n) mstep(d);
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, g, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0;
    ack = 0; err = 0; rty = 0; stall = 0; sdat = '0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    zero_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  task automatic v(input logic [3:0] c, s, input logic a, e, stl_i,
                   input logic st, input logic [3:0] g, o, input logic ss,
                   input logic [3:0] ao, eo, sto);
    vec_t x;
    x.cyc = c; x.stb = s; x.ack = a; x.err = e; x.stall = stl_i;
    x.st = st; x.gnt = g; x.outst = o; x.sstb = ss; x.acko = ao; x.erro = eo; x.stl = sto;
    tbl.push_back(x);
  endtask

  initial begin
    rst_n = 1'b1;
    zero_in();
    #1 rst_n = 1'b0;
    #1 chk("reset_state", {r_st, r_gnt, r_out, r_cyc, r_stb, r_tga, r_stl, r_ack},
           {1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0});
    tick();
    tick();
    rst_n = 1'b1;

    // Round-robin walk 0,1,2,3,0 with IDLE gaps, throttle, abort, stray acks.
    v(4'b1111, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'd0, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b1111, 4'b0001, 0, 0, 0,  1, 4'b0001, 4'd0, 1, 4'b0000, 4'b0000, 4'b1110);
    v(4'b1111, 4'b0000, 1, 0, 0,  1, 4'b0001, 4'd1, 0, 4'b0001, 4'b0000, 4'b1110);
    v(4'b1110, 4'b0000, 0, 0, 0,  1, 4'b0001, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110);
    v(4'b1110, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'd0, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b1110, 4'b0010, 0, 0, 0,  1, 4'b0010, 4'd0, 1, 4'b0000, 4'b0000, 4'b1101);
    v(4'b1110, 4'b0000, 1, 0, 0,  1, 4'b0010, 4'd1, 0, 4'b0010, 4'b0000, 4'b1101);
    v(4'b1100, 4'b0000, 0, 0, 0,  1, 4'b0010, 4'd0, 0, 4'b0000, 4'b0000, 4'b1101);
    v(4'b1100, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'd0, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b1100, 4'b0100, 0, 0, 1,  1, 4'b0100, 4'd0, 1, 4'b0000, 4'b0000, 4'b1111);
    v(4'b1100, 4'b0100, 0, 0, 0,  1, 4'b0100, 4'd0, 1, 4'b0000, 4'b0000, 4'b1011);
    v(4'b1100, 4'b0100, 0, 0, 0,  1, 4'b0100, 4'd1, 1, 4'b0000, 4'b0000, 4'b1011);
    v(4'b1100, 4'b0100, 0, 1, 0,  1, 4'b0100, 4'd2, 1, 4'b0000, 4'b0100, 4'b1011);
    v(4'b1100, 4'b0000, 0, 1, 0,  1, 4'b0100, 4'd2, 0, 4'b0000, 4'b0100, 4'b1011);
    v(4'b1100, 4'b0000, 0, 0, 0,  1, 4'b0100, 4'd1, 0, 4'b0000, 4'b0000, 4'b1011);
    v(4'b1000, 4'b0000, 0, 0, 0,  1, 4'b0100, 4'd1, 0, 4'b0000, 4'b0000, 4'b1011);
    v(4'b1000, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'd0, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b1001, 4'b1000, 0, 0, 0,  1, 4'b1000, 4'd0, 1, 4'b0000, 4'b0000, 4'b0111);
    v(4'b1001, 4'b1000, 0, 0, 0,  1, 4'b1000, 4'd1, 1, 4'b0000, 4'b0000, 4'b0111);
    v(4'b1001, 4'b1000, 0, 0, 0,  1, 4'b1000, 4'd2, 1, 4'b0000, 4'b0000, 4'b0111);
    v(4'b1001, 4'b1000, 0, 0, 0,  1, 4'b1000, 4'd3, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b1001, 4'b1000, 1, 0, 0,  1, 4'b1000, 4'd3, 1, 4'b1000, 4'b0000, 4'b0111);
    v(4'b0001, 4'b0000, 0, 0, 0,  1, 4'b1000, 4'd3, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b0001, 4'b0000, 1, 0, 0,  0, 4'b0000, 4'd0, 0, 4'b0000, 4'b0000, 4'b1111);
    v(4'b0001, 4'b0000, 0, 0, 0,  1, 4'b0001, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110);
    v(4'b0001, 4'b0000, 1, 0, 0,  1, 4'b0001, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110);
    v(4'b0000, 4'b0000, 0, 0, 0,  1, 4'b0001, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110);
    v(4'b0000, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'd0, 0, 4'b0000, 4'b0000, 4'b1111);

    foreach (tbl[i]) begin
      tick();
      cyc = tbl[i].cyc; stb = tbl[i].stb; ack = tbl[i].ack; err = tbl[i].err;
      stall = tbl[i].stall; rty = 0;
      we = 4'($urandom); adr = 48'({$urandom, $urandom}); dat = {$urandom, $urandom};
      sdat = 16'($urandom);
      #2;
      tests++;
      if ({r_st, r_gnt, r_out, r_stb, r_ack, r_err, r_stl} !==
          {tbl[i].st, tbl[i].gnt, tbl[i].outst, tbl[i].sstb, tbl[i].acko, tbl[i].erro, tbl[i].stl}) begin
        fails++;
        $display("FAIL vec%0d got st=%b gnt=%b out=%0d stb=%b ack=%b err=%b stall=%b exp st=%b gnt=%b out=%0d stb=%b ack=%b err=%b stall=%b",
                 i, r_st, r_gnt, r_out, r_stb, r_ack, r_err, r_stl, tbl[i].st, tbl[i].gnt,
                 tbl[i].outst, tbl[i].sstb, tbl[i].acko, tbl[i].erro, tbl[i].stl);
      end
    end

    // Fixed priority: channel 1 beats channel 2 every time.
    do_reset();
    cyc = 4'b0110;
    #1 chk("fp_idle", 32'(f_st), 32'(0));
    tick();
    chk("fp_gnt_first", 32'(f_gnt), 32'(4'b0010));
    for (int r = 0; r < 3; r++) begin
      cyc = 4'b0100;
      tick();
      cyc = 4'b0110;
      #1 chk("fp_gap", 32'(f_st), 32'(0));
      tick();
      chk("fp_starve", 32'(f_gnt), 32'(4'b0010));
    end

    // MAX_OUTST=2 throttle on fixed-priority instance (owner ch1).
    cyc = 4'b0010; stb = 4'b0010;
    #1 chk("fp_stb0", 32'(f_stb), 32'(1));
    tick();
    #1 chk("fp_out1", 32'(f_out), 32'(1));
    tick();
    #1 chk("fp_full", {f_out, f_stb, f_stl[1]}, {4'd2, 1'b0, 1'b1});
    tick();
    #1 chk("fp_full_hold", {f_out, f_stb}, {4'd2, 1'b0});
    ack = 1;
    #1 chk("fp_ack_stb", {f_stb, f_ack, f_stl[1]}, {1'b1, 4'b0010, 1'b0});
    tick();
    ack = 0; stb = 0;
    #1 chk("fp_out_hold", 32'(f_out), 32'(2));

    // Reset in the middle of a burst.
    do_reset();
    cyc = 4'b1111; stb = 4'b0001;
    tick(); tick(); tick();
    chk("burst_outst", {r_out, r_gnt, r_cyc}, {4'd2, 4'b0001, 1'b1});
    rst_n = 1'b0;
    #1 chk("rst_mid", {r_cyc, r_stb, r_tga, r_st, r_gnt, r_out, r_stl, f_cyc, f_stl},
           {1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 4'hF});
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("rel_idle", {r_st, r_gnt}, {1'b0, 4'h0});
    tick();
    chk("rel_first", {r_gnt, f_gnt}, {4'b0001, 4'b0001});

    // Random traffic, checked by the model at every negedge.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) cyc[k] = ~cyc[k];
      stb   = 4'($urandom);
      we    = 4'($urandom);
      adr   = 48'({$urandom, $urandom});
      dat   = {$urandom, $urandom};
      ack   = ($urandom_range(0, 3) == 0);
      err   = ($urandom_range(0, 15) == 0);
      rty   = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 3) == 0);
      sdat  = 16'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
    end
    tick();
    rst_n = 1'b1;
    zero_in();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
